// File: rtl/pipe_mem_wb_multi_if.sv
// MEM->WB pipeline bundle: upstream controls and payload in, last-slot contents, hazard flags and debug count out.
interface pipe_mem_wb_multi_if #(
  parameter int N  = 32,
  parameter int AW = 4,
  parameter int CW = 16
);
  logic          Stall;
  logic          Flush;
  logic          Valid_i;
  logic [N-1:0]  ReadData_i;
  logic [N-1:0]  AluResult_i;
  logic [AW-1:0] A3_i;
  logic          RF_WE_i;
  logic          MemWE_i;
  logic          WBSelect_i;
  logic [AW-1:0] RA1_i;
  logic [AW-1:0] RA2_i;

  logic [N-1:0]  ReadData_o;
  logic [N-1:0]  AluResult_o;
  logic [AW-1:0] A3_o;
  logic          Valid_o;
  logic          RF_WE_o;
  logic          MemWE_o;
  logic          WBSelect_o;
  logic [N-1:0]  WBData_o;
  logic          Match1_o;
  logic          Match2_o;
  logic [CW-1:0] StallCnt_o;

  modport master (
    output Stall, Flush, Valid_i, ReadData_i, AluResult_i, A3_i,
           RF_WE_i, MemWE_i, WBSelect_i, RA1_i, RA2_i,
    input  ReadData_o, AluResult_o, A3_o, Valid_o, RF_WE_o, MemWE_o,
           WBSelect_o, WBData_o, Match1_o, Match2_o, StallCnt_o
  );

  modport slave (
    input  Stall, Flush, Valid_i, ReadData_i, AluResult_i, A3_i,
           RF_WE_i, MemWE_i, WBSelect_i, RA1_i, RA2_i,
    output ReadData_o, AluResult_o, A3_o, Valid_o, RF_WE_o, MemWE_o,
           WBSelect_o, WBData_o, Match1_o, Match2_o, StallCnt_o
  );
endinterface

// File: rtl/pipe_mem_wb_multi.sv
// MEM->WB pipeline of STAGES slots with per-slot valid, flush and stall; outputs appear STAGES-1 edges after capture.
// Stall freezes every slot and drops the input (upstream holds it); flush beats stall and only clears valids.
module pipe_mem_wb_multi #(
  parameter int N      = 32,
  parameter int AW     = 4,
  parameter int STAGES = 1,
  parameter int CW     = 16
) (
  input  logic               CLK,
  input  logic               RST,
  pipe_mem_wb_multi_if.slave bus
);

  typedef struct packed {
    logic          vld;
    logic [N-1:0]  rd;
    logic [N-1:0]  alu;
    logic [AW-1:0] a3;
    logic          rf_we;
    logic          mem_we;
    logic          wb_sel;
  } slot_t;

  generate
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
      $error("pipe_mem_wb_multi: STAGES must be in 1..4");
    end
  endgenerate

  slot_t         slot_q [STAGES];
  slot_t         slot_d [STAGES];
  slot_t         last;
  logic [CW-1:0] stall_cnt_q;
  logic [CW-1:0] stall_cnt_d;
  logic          match1;
  logic          match2;

  always_comb begin
    slot_d = slot_q;
    if (bus.Flush) begin
      // Payload fields are left in place; only the valid bits matter after a flush.
      for (int k = 0; k < STAGES; k++) begin
        slot_d[k].vld = 1'b0;
      end
    end else if (!bus.Stall) begin
      slot_d[0].vld    = bus.Valid_i;
      slot_d[0].rd     = bus.ReadData_i;
      slot_d[0].alu    = bus.AluResult_i;
      slot_d[0].a3     = bus.A3_i;
      slot_d[0].rf_we  = bus.RF_WE_i;
      slot_d[0].mem_we = bus.MemWE_i;
      slot_d[0].wb_sel = bus.WBSelect_i;
      for (int k = 1; k < STAGES; k++) begin
        slot_d[k] = slot_q[k-1];
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (bus.Stall && !bus.Flush && (stall_cnt_q != {CW{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CW'(1);
    end
  end

  // Hazard flags look only at registered slot state; no bypass of same-cycle inputs.
  always_comb begin
    match1 = 1'b0;
    match2 = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      if (slot_q[k].vld && slot_q[k].rf_we && (slot_q[k].a3 == bus.RA1_i)) match1 = 1'b1;
      if (slot_q[k].vld && slot_q[k].rf_we && (slot_q[k].a3 == bus.RA2_i)) match2 = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int k = 0; k < STAGES; k++) begin
        slot_q[k] <= '0;
      end
      stall_cnt_q <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        slot_q[k] <= slot_d[k];
      end
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign last            = slot_q[STAGES-1];
  assign bus.ReadData_o  = last.rd;
  assign bus.AluResult_o = last.alu;
  assign bus.A3_o        = last.a3;
  assign bus.Valid_o     = last.vld;
  assign bus.RF_WE_o     = last.rf_we  & last.vld;
  assign bus.MemWE_o     = last.mem_we & last.vld;
  assign bus.WBSelect_o  = last.wb_sel;
  assign bus.WBData_o    = last.wb_sel ? last.rd : last.alu;
  assign bus.Match1_o    = match1;
  assign bus.Match2_o    = match2;
  assign bus.StallCnt_o  = stall_cnt_q;

endmodule

// File: tb/tb_pipe_mem_wb_multi.sv
// Directed bench: three instances (STAGES=1, STAGES=2, STAGES=3 with CW=3) share one stimulus stream.
module tb_pipe_mem_wb_multi;

  logic        clk;
  logic        rst_n;
  logic        stall, flush, valid_i, rf_we_i, mem_we_i, wb_sel_i;
  logic [31:0] rd_i, alu_i;
  logic [3:0]  a3_i, ra1_i, ra2_i;

  int vecs = 0;
  int errs = 0;

  pipe_mem_wb_multi_if #(.N(32), .AW(4), .CW(16)) if1 ();
  pipe_mem_wb_multi_if #(.N(32), .AW(4), .CW(16)) if2 ();
  pipe_mem_wb_multi_if #(.N(32), .AW(4), .CW(3))  if3 ();

  assign if1.Stall = stall;     assign if2.Stall = stall;     assign if3.Stall = stall;
  assign if1.Flush = flush;     assign if2.Flush = flush;     assign if3.Flush = flush;
  assign if1.Valid_i = valid_i; assign if2.Valid_i = valid_i; assign if3.Valid_i = valid_i;
  assign if1.ReadData_i = rd_i; assign if2.ReadData_i = rd_i; assign if3.ReadData_i = rd_i;
  assign if1.AluResult_i = alu_i; assign if2.AluResult_i = alu_i; assign if3.AluResult_i = alu_i;
  assign if1.A3_i = a3_i;       assign if2.A3_i = a3_i;       assign if3.A3_i = a3_i;
  assign if1.RF_WE_i = rf_we_i; assign if2.RF_WE_i = rf_we_i; assign if3.RF_WE_i = rf_we_i;
  assign if1.MemWE_i = mem_we_i; assign if2.MemWE_i = mem_we_i; assign if3.MemWE_i = mem_we_i;
  assign if1.WBSelect_i = wb_sel_i; assign if2.WBSelect_i = wb_sel_i; assign if3.WBSelect_i = wb_sel_i;
  assign if1.RA1_i = ra1_i;     assign if2.RA1_i = ra1_i;     assign if3.RA1_i = ra1_i;
  assign if1.RA2_i = ra2_i;     assign if2.RA2_i = ra2_i;     assign if3.RA2_i = ra2_i;

  pipe_mem_wb_multi #(.N(32), .AW(4), .STAGES(1), .CW(16)) u1 (.CLK(clk), .RST(rst_n), .bus(if1));
  pipe_mem_wb_multi #(.N(32), .AW(4), .STAGES(2), .CW(16)) u2 (.CLK(clk), .RST(rst_n), .bus(if2));
  pipe_mem_wb_multi #(.N(32), .AW(4), .STAGES(3), .CW(3))  u3 (.CLK(clk), .RST(rst_n), .bus(if3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change at the falling edge; outputs are sampled there too, away from the rising edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    stall = 0; flush = 0; valid_i = 0; rf_we_i = 0; mem_we_i = 0; wb_sel_i = 0;
    rd_i = '0; alu_i = '0; a3_i = '0; ra1_i = '0; ra2_i = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    valid_i = 1; rf_we_i = 1; mem_we_i = 1; wb_sel_i = 1;
    rd_i = 32'hDEADBEEF; alu_i = 32'h12345678; a3_i = 4'd9; ra1_i = 4'd9; ra2_i = 4'd9;
    step(); step();
    stall = 1; step();
    stall = 0;
    rst_n = 1'b0;
    #1;
    vecs++;
    if (if2.ReadData_o !== 32'h0 || if2.AluResult_o !== 32'h0 || if2.WBData_o !== 32'h0) begin
      errs++;
      $display("FAIL reset_data: rd=%h alu=%h wb=%h required all 0", if2.ReadData_o, if2.AluResult_o, if2.WBData_o);
    end
    vecs++;
    if ({if2.A3_o, if2.Valid_o, if2.RF_WE_o, if2.MemWE_o, if2.WBSelect_o} !== 8'h00) begin
      errs++;
      $display("FAIL reset_ctrl: a3=%0d v=%b rfwe=%b mwe=%b sel=%b required all 0",
               if2.A3_o, if2.Valid_o, if2.RF_WE_o, if2.MemWE_o, if2.WBSelect_o);
    end
    vecs++;
    if ({if2.Match1_o, if2.Match2_o} !== 2'b00 || if2.StallCnt_o !== 16'd0) begin
      errs++;
      $display("FAIL reset_match_cnt: m1=%b m2=%b cnt=%0d required 0 0 0", if2.Match1_o, if2.Match2_o, if2.StallCnt_o);
    end
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_pass_through();
    do_reset();
    valid_i = 1; rf_we_i = 1; mem_we_i = 1; wb_sel_i = 1;
    rd_i = 32'h7894ACD0; alu_i = 32'h00000002; a3_i = 4'b0011;
    step();
    vecs++;
    if (if1.AluResult_o !== 32'h2 || if1.A3_o !== 4'd3) begin
      errs++;
      $display("FAIL pass_fields: alu=%h a3=%0d required 00000002 3", if1.AluResult_o, if1.A3_o);
    end
    vecs++;
    if (if1.RF_WE_o !== 1'b1 || if1.MemWE_o !== 1'b1 || if1.Valid_o !== 1'b1) begin
      errs++;
      $display("FAIL pass_ctrl: rfwe=%b mwe=%b v=%b required 1 1 1", if1.RF_WE_o, if1.MemWE_o, if1.Valid_o);
    end
    vecs++;
    if (if1.WBData_o !== 32'h7894ACD0) begin
      errs++;
      $display("FAIL pass_wb_mem: got %h required 7894acd0", if1.WBData_o);
    end
    wb_sel_i = 0;
    step();
    vecs++;
    if (if1.WBData_o !== 32'h00000002) begin
      errs++;
      $display("FAIL pass_wb_alu: got %h required 00000002", if1.WBData_o);
    end
    valid_i = 0;
    step();
    vecs++;
    if (if1.Valid_o !== 1'b0 || if1.RF_WE_o !== 1'b0 || if1.MemWE_o !== 1'b0) begin
      errs++;
      $display("FAIL bubble_gate: v=%b rfwe=%b mwe=%b required 0 0 0", if1.Valid_o, if1.RF_WE_o, if1.MemWE_o);
    end
  endtask

  task automatic test_depth();
    logic [31:0] exp_alu [3];
    exp_alu[0] = 32'h11; exp_alu[1] = 32'h22; exp_alu[2] = 32'h33;
    do_reset();
    valid_i = 1; rf_we_i = 1;
    alu_i = exp_alu[0]; step();
    alu_i = exp_alu[1]; step();
    vecs++;
    if (if3.Valid_o !== 1'b0) begin
      errs++;
      $display("FAIL depth_early: valid=%b required 0 after 2nd edge", if3.Valid_o);
    end
    alu_i = exp_alu[2]; step();
    valid_i = 0; alu_i = 32'hFF;
    for (int i = 0; i < 3; i++) begin
      vecs++;
      if (if3.AluResult_o !== exp_alu[i] || if3.Valid_o !== 1'b1) begin
        errs++;
        $display("FAIL depth_edge%0d: alu=%h v=%b required %h 1", i + 3, if3.AluResult_o, if3.Valid_o, exp_alu[i]);
      end
      step();
    end
  endtask

  task automatic test_stall_flush();
    do_reset();
    valid_i = 1; rf_we_i = 1;
    alu_i = 32'h11; step();
    alu_i = 32'h22; step();
    alu_i = 32'h99; stall = 1;
    for (int i = 0; i < 4; i++) step();
    vecs++;
    if (if2.AluResult_o !== 32'h11 || if2.Valid_o !== 1'b1 || if2.StallCnt_o !== 16'd4) begin
      errs++;
      $display("FAIL stall_hold: alu=%h v=%b cnt=%0d required 11 1 4", if2.AluResult_o, if2.Valid_o, if2.StallCnt_o);
    end
    flush = 1;
    step();
    vecs++;
    if (if2.Valid_o !== 1'b0 || if2.RF_WE_o !== 1'b0 || if2.StallCnt_o !== 16'd4) begin
      errs++;
      $display("FAIL flush_stall: v=%b rfwe=%b cnt=%0d required 0 0 4", if2.Valid_o, if2.RF_WE_o, if2.StallCnt_o);
    end
    flush = 0; stall = 0; alu_i = 32'h55;
    step();
    valid_i = 0;
    vecs++;
    if (if2.Valid_o !== 1'b0) begin
      errs++;
      $display("FAIL flush_drain: v=%b required 0", if2.Valid_o);
    end
    step();
    vecs++;
    if (if2.Valid_o !== 1'b1 || if2.AluResult_o !== 32'h55) begin
      errs++;
      $display("FAIL post_flush: v=%b alu=%h required 1 55", if2.Valid_o, if2.AluResult_o);
    end
  endtask

  task automatic test_match();
    do_reset();
    valid_i = 1; rf_we_i = 1; a3_i = 4'd5; step();
    rf_we_i = 0; a3_i = 4'd7; step();
    valid_i = 0;
    ra1_i = 4'd5; ra2_i = 4'd7;
    #1;
    vecs++;
    if (if2.Match1_o !== 1'b1 || if2.Match2_o !== 1'b0) begin
      errs++;
      $display("FAIL match_basic: m1=%b m2=%b required 1 0", if2.Match1_o, if2.Match2_o);
    end
    ra1_i = 4'd3; ra2_i = 4'd5;
    #1;
    vecs++;
    if (if2.Match1_o !== 1'b0 || if2.Match2_o !== 1'b1) begin
      errs++;
      $display("FAIL match_swap: m1=%b m2=%b required 0 1", if2.Match1_o, if2.Match2_o);
    end
    flush = 1; ra1_i = 4'd5;
    step();
    flush = 0;
    vecs++;
    if (if2.Match1_o !== 1'b0 || if2.Match2_o !== 1'b0) begin
      errs++;
      $display("FAIL match_flushed: m1=%b m2=%b required 0 0", if2.Match1_o, if2.Match2_o);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    stall = 1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 5 || i == 7 || i == 10) begin
        vecs++;
        if (if3.StallCnt_o !== ((i < 7) ? 3'(i) : 3'd7)) begin
          errs++;
          $display("FAIL sat_edge%0d: cnt=%0d required %0d", i, if3.StallCnt_o, (i < 7) ? i : 7);
        end
      end
    end
    stall = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_pass_through();
    test_depth();
    test_stall_flush();
    test_match();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/pipe_mem_wb_multi.md
# pipe_mem_wb_multi

Parametrised MEM→WB pipeline register, successor to the single-stage MEM/WB latch. Carries read data, ALU result, destination register and write-back controls through `STAGES` register slots, adds per-slot valid tracking with stall and flush, and selects the final write-back value. It also provides register-match flags for hazard logic and a saturating stall counter for debug. It sits between data memory and the register file.

## Interface
- `N`, 32, data width of ReadData/AluResult/WB data
- `AW`, 4, register address width (A3, RA1, RA2)
- `STAGES`, 1, number of register slots, legal range 1..4
- `CW`, 16, stall counter width
- `CLK` in 1, single clock, all state updates on rising edge
- `RST` in 1, asynchronous, active-low reset
- `Stall` in 1, hold all slots
- `Flush` in 1, invalidate all slots
- `Valid_i` in 1, incoming instruction is real (0 = bubble)
- `ReadData_i` in N, memory read data
- `AluResult_i` in N, ALU result
- `A3_i` in AW, destination register
- `RF_WE_i` in 1, register file write enable
- `MemWE_i` in 1, memory write enable (carried for trace)
- `WBSelect_i` in 1, 1 = ReadData, 0 = AluResult
- `RA1_i`, `RA2_i` in AW, source registers from decode for match check
- `ReadData_o`, `AluResult_o` out N, last slot contents
- `A3_o` out AW, last slot destination
- `Valid_o` out 1, last slot valid
- `RF_WE_o`, `MemWE_o` out 1, last slot enables ANDed with `Valid_o`
- `WBSelect_o` out 1, last slot select (raw)
- `WBData_o` out N, `WBSelect_o ? ReadData_o : AluResult_o`
- `Match1_o`, `Match2_o` out 1, RA1/RA2 hits a pending write in any slot
- `StallCnt_o` out CW, saturating count of stalled cycles

## Operation
- Slot k (0..STAGES-1) stores {valid, ReadData, AluResult, A3, RF_WE, MemWE, WBSelect}; slot 0 is input side, slot STAGES-1 drives outputs.
- Priority per edge: Flush > Stall > shift.
- Flush=1: every slot's valid cleared; data fields may keep their values. The slot's incoming value is discarded. Stall is ignored that cycle.
- Stall=1, Flush=0: every slot holds all fields. Input is discarded; upstream must hold it.
- Otherwise shift: slot0 ← inputs (valid ← Valid_i), slot k ← slot k-1.
- Control outputs `RF_WE_o` and `MemWE_o` are 0 whenever `Valid_o`=0. Bubbles never write.
- `Match1_o` = OR over slots of (valid & RF_WE & A3 == RA1_i). Same for `Match2_o` with RA2_i. Purely combinational on current slot state. Register 0 is not special-cased.
- `StallCnt_o` increments by 1 on each edge with Stall=1 and Flush=0. It saturates at 2^CW-1 and never wraps. It is cleared only by reset.
- `WBData_o` is combinational from the last slot.
- STAGES outside 1..4: elaboration error.

## Timing
- Reset (RST=0, async, immediate): all slot fields 0, so all outputs 0, Match flags 0, StallCnt_o 0. Reset mid-stream drops all in-flight entries.
- First edge after RST rises behaves as a normal edge.
- Latency: an input accepted at edge t appears on outputs after edge t+STAGES-1. STAGES=1 means visible right after the capturing edge, as in the single-stage latch.
- Each stalled cycle adds one cycle to the latency of every in-flight entry.
- Flush at edge t: `Valid_o`=0 after edge t. The input at edge t+1 enters normally.
- Simultaneous Stall and Flush: the flush takes effect and StallCnt_o does not increment.
- Match flags reflect state after the most recent edge. There is no same-cycle bypass of `*_i` inputs.

## Test plan
- Reset: drive RST=0 mid-run with N=32, STAGES=2 → every output and StallCnt_o read 0 before any clock edge.
- Pass-through, N=32, STAGES=1: ReadData_i=0x7894ACD0, AluResult_i=0x00000002, A3_i=4'b0011, RF_WE_i=MemWE_i=WBSelect_i=1, Valid_i=1 → after one edge AluResult_o=0x00000002, A3_o=3, RF_WE_o=1, WBData_o=0x7894ACD0. Repeat with WBSelect_i=0 → WBData_o=0x00000002.
- Depth, STAGES=3: inject AluResult 0x11, 0x22, 0x33 on consecutive edges → outputs show 0x11 after the 3rd edge, 0x22 after the 4th, 0x33 after the 5th.
- Stall/flush, STAGES=2: with 0x11 and 0x22 in flight, Stall=1 for 4 edges → outputs frozen and StallCnt_o=4. Then Flush=1 together with Stall=1 → Valid_o=0, RF_WE_o=0, StallCnt_o still 4.
- Match: slots hold A3=5 (RF_WE=1, valid) and A3=7 (RF_WE=0). RA1_i=5 → Match1_o=1. RA2_i=7 → Match2_o=0. After a flush, RA1_i=5 → Match1_o=0.
- Saturation, CW=3: hold Stall=1 for 10 edges → StallCnt_o stops at 7.
